// File: rtl/time_pkg.sv
// Shared definitions for time-set entry: FSM encodings, BCD digit limits and a load sanitiser.
package time_pkg;

  typedef enum logic [3:0] {
    StRun    = 4'd0,
    StEdit1  = 4'd1,
    StEdit2  = 4'd2,
    StEdit3  = 4'd3,
    StEdit4  = 4'd4,
    StEdit5  = 4'd5,
    StEdit6  = 4'd6,
    StCommit = 4'd7
  } tsState;

  localparam logic [3:0] LimHHt  = 4'd2;
  localparam logic [3:0] LimHHo  = 4'd9;
  localparam logic [3:0] LimHHo2 = 4'd3;  // HH ones limit while HH tens is 2
  localparam logic [3:0] LimMMt  = 4'd5;
  localparam logic [3:0] LimMMo  = 4'd9;
  localparam logic [3:0] LimSSt  = 4'd5;
  localparam logic [3:0] LimSSo  = 4'd9;

  function automatic logic [3:0] clampDigit(logic [3:0] d, logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

  // Keeps every digit legal even if the live time bus carries an out-of-range value.
  function automatic logic [23:0] sanitizeTime(logic [23:0] t);
    logic [3:0] hht;
    logic [3:0] hhoLim;
    hht    = clampDigit(t[23:20], LimHHt);
    hhoLim = (hht == 4'd2) ? LimHHo2 : LimHHo;
    return {hht, clampDigit(t[19:16], hhoLim), clampDigit(t[15:12], LimMMt),
            clampDigit(t[11:8], LimMMo), clampDigit(t[7:4], LimSSt), clampDigit(t[3:0], LimSSo)};
  endfunction

endpackage

// File: rtl/bcd_digit_inc.sv
// Limit-aware BCD digit increment: wraps to 0 once the digit reaches its limit.
module bcd_digit_inc (
  input  logic [3:0] digitIn,
  input  logic [3:0] limit,
  output logic [3:0] digitOut
);

  always_comb begin
    digitOut = (digitIn >= limit) ? 4'd0 : digitIn + 4'd1;
  end

endmodule

// File: rtl/time_set_entry.sv
// Time-set entry FSM: captures the live time, lets the user edit it digit by digit, then commits.
module time_set_entry
  import time_pkg::*;
#(
  parameter int unsigned BLINK_HALF = 25_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        setMode,
  input  logic        nextDigit,
  input  logic        incDigit,
  input  logic [23:0] currentBits,
  output logic [23:0] setBits,
  output logic [3:0]  state,
  output logic        blink
);

  localparam int unsigned CntW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(BLINK_HALF - 1);

  tsState          stateQ, stateD;
  logic [23:0]     setBitsQ, setBitsD;
  logic            setModeQ;
  logic            blinkQ, blinkD;
  logic [CntW-1:0] blinkCntQ, blinkCntD;
  logic            editEntry;
  logic [3:0]      curDigit, curLimit, incOut;
  logic [23:0]     incBits;

  // Digit under the cursor and its current limit.
  always_comb begin
    curDigit = 4'd0;
    curLimit = LimSSo;
    case (stateQ)
      StEdit6: begin curDigit = setBitsQ[23:20]; curLimit = LimHHt; end
      StEdit5: begin
        curDigit = setBitsQ[19:16];
        curLimit = (setBitsQ[23:20] == 4'd2) ? LimHHo2 : LimHHo;
      end
      StEdit4: begin curDigit = setBitsQ[15:12]; curLimit = LimMMt; end
      StEdit3: begin curDigit = setBitsQ[11:8];  curLimit = LimMMo; end
      StEdit2: begin curDigit = setBitsQ[7:4];   curLimit = LimSSt; end
      StEdit1: begin curDigit = setBitsQ[3:0];   curLimit = LimSSo; end
      default: ;
    endcase
  end

  bcd_digit_inc uInc (
    .digitIn  (curDigit),
    .limit    (curLimit),
    .digitOut (incOut)
  );

  always_comb begin
    incBits = setBitsQ;
    case (stateQ)
      StEdit6: begin
        incBits[23:20] = incOut;
        // Entering the 20s must pull HH ones into 20..23.
        if (incOut == 4'd2 && setBitsQ[19:16] > LimHHo2) incBits[19:16] = LimHHo2;
      end
      StEdit5: incBits[19:16] = incOut;
      StEdit4: incBits[15:12] = incOut;
      StEdit3: incBits[11:8]  = incOut;
      StEdit2: incBits[7:4]   = incOut;
      StEdit1: incBits[3:0]   = incOut;
      default: ;
    endcase
  end

  always_comb begin
    stateD    = stateQ;
    setBitsD  = setBitsQ;
    editEntry = 1'b0;
    case (stateQ)
      StRun: begin
        if (setMode && !setModeQ) begin
          setBitsD  = sanitizeTime(currentBits);
          stateD    = StEdit6;
          editEntry = 1'b1;
        end
      end
      StCommit: stateD = StRun;
      default: begin
        if (!setMode) begin
          stateD = StCommit;
        end else begin
          if (incDigit) setBitsD = incBits;
          if (nextDigit) begin
            stateD    = (stateQ == StEdit1) ? StEdit6 : tsState'(stateQ - 4'd1);
            editEntry = 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    blinkD    = 1'b0;
    blinkCntD = '0;
    if (editEntry) begin
      blinkD = 1'b1;
    end else if (stateD != StRun && stateD != StCommit) begin
      if (blinkCntQ == CntLast) begin
        blinkD = ~blinkQ;
      end else begin
        blinkD    = blinkQ;
        blinkCntD = blinkCntQ + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ    <= StRun;
      setBitsQ  <= 24'h000000;
      setModeQ  <= 1'b1;  // a held-high setMode after reset is not an edge
      blinkQ    <= 1'b0;
      blinkCntQ <= '0;
    end else begin
      stateQ    <= stateD;
      setBitsQ  <= setBitsD;
      setModeQ  <= setMode;
      blinkQ    <= blinkD;
      blinkCntQ <= blinkCntD;
    end
  end

  assign setBits = setBitsQ;
  assign state   = stateQ;
  assign blink   = blinkQ;

endmodule

// File: tb/tb_time_set_entry.sv
// Self-checking bench for time_set_entry with a short blink half-period.
module tb_time_set_entry;

  typedef struct {
    string       tag;
    logic        sm;
    logic        nd;
    logic        inc;
    logic [3:0]  st;
    logic [23:0] bits;
  } step_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        setMode = 1'b0;
  logic        nextDigit = 1'b0;
  logic        incDigit = 1'b0;
  logic [23:0] currentBits = 24'h0;
  logic [23:0] setBits;
  logic [3:0]  stateOut;
  logic        blink;

  int checks = 0;
  int failures = 0;
  step_t stim[$];
  step_t sbq[$];

  time_set_entry #(.BLINK_HALF(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .setMode     (setMode),
    .nextDigit   (nextDigit),
    .incDigit    (incDigit),
    .currentBits (currentBits),
    .setBits     (setBits),
    .state       (stateOut),
    .blink       (blink)
  );

  always #5 clk = ~clk;

  function automatic step_t mk(string tag, logic sm, logic nd, logic inc, logic [3:0] st,
                               logic [23:0] bits);
    step_t s;
    s.tag = tag; s.sm = sm; s.nd = nd; s.inc = inc; s.st = st; s.bits = bits;
    return s;
  endfunction

  task automatic drive(input step_t s);
    setMode = s.sm; nextDigit = s.nd; incDigit = s.inc;
    sbq.push_back(s);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    step_t e;
    rst_n = 1'b0; #1;
    checks++;
    if (stateOut !== 4'd0 || setBits !== 24'h0 || blink !== 1'b0) begin
      failures++;
      $display("FAIL reset: state=%0d setBits=%h blink=%b, expected 0/000000/0",
               stateOut, setBits, blink);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    stim.push_back(mk("run_pulses", 0, 1, 1, 0, 24'h000000));
    stim.push_back(mk("run_inc", 0, 0, 1, 0, 24'h000000));
    while (stim.size() > 0) begin
      drive(stim.pop_front());
      e = sbq.pop_front(); checks++;
      if (stateOut !== e.st || setBits !== e.bits) begin
        failures++;
        $display("FAIL %s: state=%0d setBits=%h, expected state=%0d setBits=%h",
                 e.tag, stateOut, setBits, e.st, e.bits);
      end
    end
  endtask

  task automatic test_load();
    step_t e;
    currentBits = 24'h123456;
    stim.push_back(mk("load", 1, 0, 0, 6, 24'h123456));
    stim.push_back(mk("load_hold", 1, 0, 0, 6, 24'h123456));
    while (stim.size() > 0) begin
      drive(stim.pop_front());
      e = sbq.pop_front(); checks++;
      if (stateOut !== e.st || setBits !== e.bits) begin
        failures++;
        $display("FAIL %s: state=%0d setBits=%h, expected state=%0d setBits=%h",
                 e.tag, stateOut, setBits, e.st, e.bits);
      end
    end
  endtask

  task automatic test_hours();
    step_t e;
    stim.push_back(mk("h_commit", 0, 0, 0, 7, 24'h123456));
    stim.push_back(mk("h_run", 0, 0, 0, 0, 24'h123456));
    stim.push_back(mk("h_load", 1, 0, 0, 6, 24'h170000));
    stim.push_back(mk("h_clamp", 1, 0, 1, 6, 24'h230000));
    stim.push_back(mk("h_wrap", 1, 0, 1, 6, 24'h030000));
    stim.push_back(mk("h_one", 1, 0, 1, 6, 24'h130000));
    stim.push_back(mk("h_two", 1, 0, 1, 6, 24'h230000));
    stim.push_back(mk("h_next", 1, 1, 0, 5, 24'h230000));
    stim.push_back(mk("hho_wrap", 1, 0, 1, 5, 24'h200000));
    while (stim.size() > 0) begin
      if (stim[0].tag == "h_load") currentBits = 24'h170000;
      drive(stim.pop_front());
      e = sbq.pop_front(); checks++;
      if (stateOut !== e.st || setBits !== e.bits) begin
        failures++;
        $display("FAIL %s: state=%0d setBits=%h, expected state=%0d setBits=%h",
                 e.tag, stateOut, setBits, e.st, e.bits);
      end
    end
  endtask

  task automatic test_minutes();
    step_t e;
    currentBits = 24'h125930;
    stim.push_back(mk("m_commit", 0, 0, 0, 7, 24'h200000));
    stim.push_back(mk("m_run", 0, 0, 0, 0, 24'h200000));
    stim.push_back(mk("m_load", 1, 0, 0, 6, 24'h125930));
    stim.push_back(mk("m_n5", 1, 1, 0, 5, 24'h125930));
    stim.push_back(mk("m_n4", 1, 1, 0, 4, 24'h125930));
    stim.push_back(mk("mmt_wrap", 1, 0, 1, 4, 24'h120930));
    stim.push_back(mk("m_n3", 1, 1, 0, 3, 24'h120930));
    stim.push_back(mk("m_n2", 1, 1, 0, 2, 24'h120930));
    stim.push_back(mk("m_n1", 1, 1, 0, 1, 24'h120930));
    stim.push_back(mk("cursor_wrap", 1, 1, 0, 6, 24'h120930));
    while (stim.size() > 0) begin
      drive(stim.pop_front());
      e = sbq.pop_front(); checks++;
      if (stateOut !== e.st || setBits !== e.bits) begin
        failures++;
        $display("FAIL %s: state=%0d setBits=%h, expected state=%0d setBits=%h",
                 e.tag, stateOut, setBits, e.st, e.bits);
      end
    end
  endtask

  task automatic test_same_cycle();
    step_t e;
    stim.push_back(mk("s_n5", 1, 1, 0, 5, 24'h120930));
    stim.push_back(mk("s_n4", 1, 1, 0, 4, 24'h120930));
    stim.push_back(mk("s_n3", 1, 1, 0, 3, 24'h120930));
    stim.push_back(mk("s_n2", 1, 1, 0, 2, 24'h120930));
    stim.push_back(mk("inc_and_next", 1, 1, 1, 1, 24'h120940));
    stim.push_back(mk("sso_inc", 1, 0, 1, 1, 24'h120941));
    while (stim.size() > 0) begin
      drive(stim.pop_front());
      e = sbq.pop_front(); checks++;
      if (stateOut !== e.st || setBits !== e.bits) begin
        failures++;
        $display("FAIL %s: state=%0d setBits=%h, expected state=%0d setBits=%h",
                 e.tag, stateOut, setBits, e.st, e.bits);
      end
    end
  endtask

  task automatic test_commit();
    step_t e;
    stim.push_back(mk("c_n6", 1, 1, 0, 6, 24'h120941));
    stim.push_back(mk("c_n5", 1, 1, 0, 5, 24'h120941));
    stim.push_back(mk("c_n4", 1, 1, 0, 4, 24'h120941));
    stim.push_back(mk("c_n3", 1, 1, 0, 3, 24'h120941));
    stim.push_back(mk("commit_ign_inc", 0, 0, 1, 7, 24'h120941));
    stim.push_back(mk("commit_to_run", 0, 1, 1, 0, 24'h120941));
    stim.push_back(mk("run_hold", 0, 1, 1, 0, 24'h120941));
    while (stim.size() > 0) begin
      drive(stim.pop_front());
      e = sbq.pop_front(); checks++;
      if (stateOut !== e.st || setBits !== e.bits) begin
        failures++;
        $display("FAIL %s: state=%0d setBits=%h, expected state=%0d setBits=%h",
                 e.tag, stateOut, setBits, e.st, e.bits);
      end
    end
  endtask

  task automatic test_wrap_limits();
    step_t e;
    currentBits = 24'h235959;
    stim.push_back(mk("w_load", 1, 0, 0, 6, 24'h235959));
    stim.push_back(mk("w_hht", 1, 0, 1, 6, 24'h035959));
    stim.push_back(mk("w_n5", 1, 1, 0, 5, 24'h035959));
    stim.push_back(mk("w_hho", 1, 0, 1, 5, 24'h045959));
    stim.push_back(mk("w_n4", 1, 1, 0, 4, 24'h045959));
    stim.push_back(mk("w_mmt", 1, 0, 1, 4, 24'h040959));
    stim.push_back(mk("w_n3", 1, 1, 0, 3, 24'h040959));
    stim.push_back(mk("w_mmo", 1, 0, 1, 3, 24'h040059));
    stim.push_back(mk("w_n2", 1, 1, 0, 2, 24'h040059));
    stim.push_back(mk("w_sst", 1, 0, 1, 2, 24'h040009));
    stim.push_back(mk("w_n1", 1, 1, 0, 1, 24'h040009));
    stim.push_back(mk("w_sso", 1, 0, 1, 1, 24'h040000));
    stim.push_back(mk("w_commit", 0, 0, 0, 7, 24'h040000));
    stim.push_back(mk("w_run", 0, 0, 0, 0, 24'h040000));
    while (stim.size() > 0) begin
      drive(stim.pop_front());
      e = sbq.pop_front(); checks++;
      if (stateOut !== e.st || setBits !== e.bits) begin
        failures++;
        $display("FAIL %s: state=%0d setBits=%h, expected state=%0d setBits=%h",
                 e.tag, stateOut, setBits, e.st, e.bits);
      end
    end
  endtask

  task automatic test_blink();
    logic expB;
    drive(mk("b_load", 1, 0, 0, 6, 24'h040000));
    void'(sbq.pop_front());
    checks++;
    if (blink !== 1'b1) begin
      failures++;
      $display("FAIL blink_entry: blink=%b, expected 1", blink);
    end
    for (int k = 1; k <= 13; k++) begin
      drive(mk("b_idle", 1, 0, 0, 6, 24'h040000));
      void'(sbq.pop_front());
      expB = ((k / 4) % 2) == 0;
      checks++;
      if (blink !== expB || stateOut !== 4'd6) begin
        failures++;
        $display("FAIL blink_cycle%0d: blink=%b state=%0d, expected blink=%b state=6",
                 k, blink, stateOut, expB);
      end
    end
    drive(mk("b_next", 1, 1, 0, 5, 24'h040000));
    void'(sbq.pop_front());
    checks++;
    if (blink !== 1'b1 || stateOut !== 4'd5) begin
      failures++;
      $display("FAIL blink_restart: blink=%b state=%0d, expected blink=1 state=5",
               blink, stateOut);
    end
  endtask

  task automatic test_reset_mid_edit();
    step_t e;
    rst_n = 1'b0; #1;
    checks++;
    if (stateOut !== 4'd0 || setBits !== 24'h0 || blink !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: state=%0d setBits=%h blink=%b, expected 0/000000/0",
               stateOut, setBits, blink);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    currentBits = 24'h123456;
    stim.push_back(mk("held_no_edit1", 1, 0, 1, 0, 24'h000000));
    stim.push_back(mk("held_no_edit2", 1, 1, 0, 0, 24'h000000));
    stim.push_back(mk("drop_mode", 0, 0, 0, 0, 24'h000000));
    stim.push_back(mk("fresh_edge", 1, 0, 0, 6, 24'h123456));
    while (stim.size() > 0) begin
      drive(stim.pop_front());
      e = sbq.pop_front(); checks++;
      if (stateOut !== e.st || setBits !== e.bits) begin
        failures++;
        $display("FAIL %s: state=%0d setBits=%h, expected state=%0d setBits=%h",
                 e.tag, stateOut, setBits, e.st, e.bits);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_hours();
    test_minutes();
    test_same_cycle();
    test_commit();
    test_wrap_limits();
    test_blink();
    test_reset_mid_edit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/time_set_entry.md
TIME_SET_ENTRY -- requirements
Module: time_set_entry

Interface
REQ-001 Parameter BLINK_HALF SHALL default to 25_000_000; it is the clk cycles per half-period of the edit-digit blink.
REQ-002 clk  input  1  system clock; all logic SHALL be rising-edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 setMode  input  1  level; high = user editing time, low = run.
REQ-005 nextDigit  input  1  single-cycle pulse, pre-shaped; advance the edit cursor.
REQ-006 incDigit  input  1  single-cycle pulse, pre-shaped; increment the digit under the cursor.
REQ-007 currentBits  input  24  live BCD time {HHt,HHo,MMt,MMo,SSt,SSo}, 4 bits each, MSB = HH tens.
REQ-008 setBits  output  24  edited BCD time, same packing; drives the clock's load-data bus.
REQ-009 state  output  4  0 = RUN, 6..1 = editing digit n (6 = HH tens ... 1 = SS ones), 7 = COMMIT.
REQ-010 blink  output  1  toggles every BLINK_HALF cycles while editing; 0 in RUN/COMMIT.

Function
REQ-011 The FSM SHALL have states RUN(0), EDIT6..EDIT1(6..1) and COMMIT(7); state output SHALL equal the encoding directly (registered, no decode).
REQ-012 In RUN, a setMode 0->1 edge SHALL load setBits <= currentBits and enter EDIT6 on the next cycle.
REQ-013 In EDITn, nextDigit SHALL move to EDIT(n-1); EDIT1 SHALL wrap to EDIT6.
REQ-014 In EDITn, incDigit SHALL increment digit n by 1 with wrap to 0 above its limit: HHt 2, HHo 9 (3 when HHt=2), MMt 5, MMo 9, SSt 5, SSo 9.
REQ-015 When HHt becomes 2 while HHo > 3, HHo SHALL be clamped to 3 in the same cycle.
REQ-016 When HHo is incremented while HHt=2 and HHo=3, HHo SHALL wrap to 0.
REQ-017 incDigit and nextDigit in the same cycle: the increment SHALL apply to the current digit, and the cursor SHALL advance in that cycle.
REQ-018 setMode 1->0 in any EDITn SHALL enter COMMIT for exactly one cycle, then RUN; pulses in that cycle SHALL be ignored.
REQ-019 In COMMIT, setBits SHALL hold the final edited value; in RUN, setBits SHALL hold its last value.
REQ-020 Pulses in RUN and COMMIT SHALL have no effect.
REQ-021 setBits and state SHALL be updated with 1-cycle latency from the qualifying input.
REQ-022 The blink counter SHALL restart at 0 with blink=1 on entry to any EDITn, including cursor moves.
REQ-023 Every setBits digit SHALL remain a legal BCD value within its limit at all times.

Reset
REQ-024 rst_n low SHALL immediately force state=0, setBits=24'h000000, blink=0 and blink counter=0, including mid-edit.
REQ-025 After rst_n release, setMode already high SHALL NOT start an edit; a fresh 0->1 edge is required (edge detector resets to 1).

Structure
REQ-026 Shared package time_pkg SHALL hold the state encodings (RUN, EDIT1..EDIT6, COMMIT) and the per-digit limit constants.
REQ-027 The limit-aware BCD increment SHALL be sub-module bcd_digit_inc (digit in, limit in, digit out), instantiated once and muxed by cursor.
REQ-028 All state SHALL reside in one clock domain; no latches and no gated clocks.

Verification
REQ-029 currentBits=24'h123456, setMode rise -> next cycle setBits=24'h123456, state=6, blink=1.
REQ-030 EDIT6 with HHt=1, HHo=7: incDigit -> setBits[23:16]=8'h23; incDigit again -> 8'h03.
REQ-031 EDIT4 (MMt=5): incDigit -> MMt=0; nextDigit x4 from EDIT4 -> state sequence 3,2,1,6.
REQ-032 EDIT2 with incDigit and nextDigit same cycle -> SSt+1 and state=1 next cycle.
REQ-033 setMode fall in EDIT3 with incDigit -> state 7 for one cycle with setBits unchanged, then state 0.
REQ-034 rst_n low mid-edit with setMode held high -> state=0 and setBits=0 asynchronously; after release, no edit until setMode toggles; BLINK_HALF=4 -> blink period of 8 cycles checked.
